l1_dcache: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache between the pipeline's data-memory port (d_mem_*) and the physical memory port. Hits complete combinationally in the request cycle so the MEM stage does not stall. Misses run a small FSM that writes back a dirty victim and then fills the 128-bit line.

---
 rtl/cache_types.sv | 13 +
 rtl/lc3b_types.sv | 7 +
 rtl/l1_dcache_control.sv | 97 +++++++++
 rtl/l1_dcache.sv | 119 +++++++++++
 tb/tb_l1_dcache.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_types.sv
// Geometry and FSM state types for the L1 data cache (8 sets x 16-byte lines).
package cache_types;

   typedef logic [127:0] lc3b_cache_line;
   typedef logic [8:0]   lc3b_cache_tag;
   typedef logic [2:0]   lc3b_cache_index;
   typedef logic [2:0]   lc3b_cache_wsel;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} cache_state_t;

   localparam int unsigned NumSets = 8;

endpackage

// File: rtl/lc3b_types.sv
// Basic LC-3b datapath types shared across the pipeline.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

endpackage

// File: rtl/l1_dcache_control.sv
// Miss FSM, pmem strobes and array load enables for l1_dcache.
// Optional hit/miss counters are built when L1_DCACHE_PERF_EN is defined.
module l1_dcache_control
   import cache_types::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic         line_hit,
   input  logic         victim_dirty,
   input  logic         pmem_resp,
   output cache_state_t state,
   output logic         mem_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic         load_write,
   output logic         load_fill,
   output logic         clear_dirty
`ifdef L1_DCACHE_PERF_EN
   ,
   output logic [15:0]  hit_count,
   output logic [15:0]  miss_count
`endif
);

   cache_state_t state_q, state_d;
   logic         req;

   assign req   = mem_read | mem_write;
   assign state = state_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Array updates are gated by reset so a pmem_resp coincident with reset is dropped.
   always_comb begin
      state_d     = state_q;
      mem_resp    = 1'b0;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      load_write  = 1'b0;
      load_fill   = 1'b0;
      clear_dirty = 1'b0;
      unique case (state_q)
         IDLE: begin
            mem_resp   = req & line_hit;
            load_write = mem_write & line_hit & ~reset;
            if (req && !line_hit) state_d = victim_dirty ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            pmem_write = 1'b1;
            if (pmem_resp) begin
               clear_dirty = ~reset;
               state_d     = ALLOCATE;
            end
         end
         ALLOCATE: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               load_fill = ~reset;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef L1_DCACHE_PERF_EN
   logic [15:0] hit_count_q, miss_count_q;
   logic        miss_pend_q;

   // miss_pend_q marks a request that missed, so its eventual completion is not a hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
         miss_pend_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && state_d != IDLE) begin
            miss_pend_q <= 1'b1;
            if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
         end
         if (mem_resp) begin
            miss_pend_q <= 1'b0;
            if (!miss_pend_q && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
         end
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 data cache, 8 sets x 128-bit lines.
// Define L1_DCACHE_PERF_EN to add the hit_count/miss_count ports.
module l1_dcache
   import lc3b_types::*;
   import cache_types::*;
(
   input  logic           clk,
   input  logic           reset,
   input  lc3b_word       mem_address,
   input  logic           mem_read,
   input  logic           mem_write,
   input  lc3b_mem_wmask  mem_byte_enable,
   input  lc3b_word       mem_wdata,
   output lc3b_word       mem_rdata,
   output logic           mem_resp,
   output lc3b_word       pmem_address,
   output logic           pmem_read,
   output logic           pmem_write,
   output lc3b_cache_line pmem_wdata,
   input  lc3b_cache_line pmem_rdata,
   input  logic           pmem_resp
`ifdef L1_DCACHE_PERF_EN
   ,
   output logic [15:0]    hit_count,
   output logic [15:0]    miss_count
`endif
);

   lc3b_cache_tag   tag;
   lc3b_cache_index index;
   lc3b_cache_wsel  wsel;
   logic            unused_addr_bit;

   assign tag             = mem_address[15:7];
   assign index           = mem_address[6:4];
   assign wsel            = mem_address[3:1];
   assign unused_addr_bit = mem_address[0];

   logic [NumSets-1:0] valid_q, dirty_q;
   lc3b_cache_tag      tag_q  [NumSets];
   lc3b_cache_line     data_q [NumSets];

   lc3b_cache_line line, merged_line;
   lc3b_word       word;
   logic           line_hit, victim_dirty;
   cache_state_t   state;
   logic           load_write, load_fill, clear_dirty;

   assign line         = data_q[index];
   assign word         = line[{wsel, 4'h0} +: 16];
   assign line_hit     = valid_q[index] && (tag_q[index] == tag);
   assign victim_dirty = valid_q[index] && dirty_q[index];

   always_comb begin
      merged_line = line;
      if (mem_byte_enable[0]) merged_line[{wsel, 4'h0} +: 8] = mem_wdata[7:0];
      if (mem_byte_enable[1]) merged_line[{wsel, 4'h8} +: 8] = mem_wdata[15:8];
   end

   l1_dcache_control u_control (
      .clk          (clk),
      .reset        (reset),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .line_hit     (line_hit),
      .victim_dirty (victim_dirty),
      .pmem_resp    (pmem_resp),
      .state        (state),
      .mem_resp     (mem_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .load_write   (load_write),
      .load_fill    (load_fill),
      .clear_dirty  (clear_dirty)
`ifdef L1_DCACHE_PERF_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (load_write)  dirty_q[index] <= 1'b1;
         if (clear_dirty) dirty_q[index] <= 1'b0;
         if (load_fill) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
         end
      end
   end

   // Tag and data arrays carry no reset; valid_q alone qualifies their contents.
   always_ff @(posedge clk) begin
      if (load_write) data_q[index] <= merged_line;
      if (load_fill) begin
         data_q[index] <= pmem_rdata;
         tag_q[index]  <= tag;
      end
   end

   always_comb begin
      mem_rdata    = mem_resp ? word : 16'h0;
      pmem_wdata   = '0;
      pmem_address = 16'h0;
      unique case (state)
         WRITEBACK: begin
            pmem_address = {tag_q[index], index, 4'h0};
            pmem_wdata   = line;
         end
         ALLOCATE: pmem_address = {mem_address[15:4], 4'h0};
         default:  pmem_address = 16'h0;
      endcase
   end

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: transaction-level cache model plus directed vectors.
module tb_l1_dcache;

   logic         clk = 1'b0;
   logic         reset;
   logic [15:0]  mem_address;
   logic         mem_read, mem_write;
   logic [1:0]   mem_byte_enable;
   logic [15:0]  mem_wdata, mem_rdata;
   logic         mem_resp;
   logic [15:0]  pmem_address;
   logic         pmem_read, pmem_write;
   logic [127:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
`ifdef L1_DCACHE_PERF_EN
   logic [15:0]  hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   l1_dcache dut (
      .clk             (clk),
      .reset           (reset),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .pmem_address    (pmem_address),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp)
`ifdef L1_DCACHE_PERF_EN
      ,
      .hit_count       (hit_count),
      .miss_count      (miss_count)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Physical memory image: word k of line L holds {L[11:0], k[3:0]}.
   logic [127:0] backing [4096];

   // Cache model: contents per set plus a queue of bus transactions still owed.
   typedef struct {
      bit           is_wb;
      logic [15:0]  addr;
      logic [127:0] data;
   } txn_t;

   bit           m_valid [8];
   bit           m_dirty [8];
   logic [8:0]   m_tag   [8];
   logic [127:0] m_data  [8];
   txn_t         m_q[$];
   int           m_hits = 0, m_misses = 0;
   bit           m_missed = 0;

   function automatic bit model_hit(input logic [15:0] a);
      return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[15:7]);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            for (int s = 0; s < 8; s++) begin
               m_valid[s] = 0;
               m_dirty[s] = 0;
            end
            m_q.delete();
            m_hits   = 0;
            m_misses = 0;
            m_missed = 0;
         end else if (m_q.size() > 0) begin
            if (pmem_resp) begin
               txn_t t;
               int   s;
               t = m_q.pop_front();
               s = int'(t.addr[6:4]);
               if (t.is_wb) begin
                  backing[t.addr[15:4]] = t.data;
                  m_dirty[s] = 0;
               end else begin
                  m_data[s]  = backing[t.addr[15:4]];
                  m_tag[s]   = t.addr[15:7];
                  m_valid[s] = 1;
                  m_dirty[s] = 0;
               end
            end
         end else if (mem_read || mem_write) begin
            int s;
            s = int'(mem_address[6:4]);
            if (model_hit(mem_address)) begin
               if (mem_write) begin
                  int b;
                  b = int'(mem_address[3:1]) * 16;
                  if (mem_byte_enable[0]) m_data[s][b +: 8]     = mem_wdata[7:0];
                  if (mem_byte_enable[1]) m_data[s][b + 8 +: 8] = mem_wdata[15:8];
                  m_dirty[s] = 1;
               end
               if (!m_missed && m_hits < 65535) m_hits++;
               m_missed = 0;
            end else begin
               if (m_valid[s] && m_dirty[s])
                  m_q.push_back('{1'b1, {m_tag[s], mem_address[6:4], 4'h0}, m_data[s]});
               m_q.push_back('{1'b0, {mem_address[15:4], 4'h0}, 128'h0});
               if (m_misses < 65535) m_misses++;
               m_missed = 1;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         logic         e_resp, e_rd, e_wr;
         logic [15:0]  e_addr, e_rdata;
         logic [127:0] e_wdata;
         @(negedge clk);
         e_resp = 0; e_rd = 0; e_wr = 0; e_addr = 0; e_rdata = 0; e_wdata = 0;
         if (m_q.size() == 0) begin
            if ((mem_read || mem_write) && model_hit(mem_address)) begin
               e_resp  = 1;
               e_rdata = m_data[mem_address[6:4]][int'(mem_address[3:1]) * 16 +: 16];
            end
         end else if (m_q[0].is_wb) begin
            e_wr = 1; e_addr = m_q[0].addr; e_wdata = m_q[0].data;
         end else begin
            e_rd = 1; e_addr = m_q[0].addr;
         end
         check("mem_resp", mem_resp, e_resp);
         check("pmem_read", pmem_read, e_rd);
         check("pmem_write", pmem_write, e_wr);
         check("pmem_address", pmem_address, e_addr);
         check("pmem_wdata", pmem_wdata, e_wdata);
         check("pmem_strobe_overlap", pmem_read & pmem_write, 1'b0);
         if (!e_resp || !mem_write) check("mem_rdata", mem_rdata, e_resp ? e_rdata : 16'h0);
`ifdef L1_DCACHE_PERF_EN
         check("hit_count", hit_count, m_hits[15:0]);
         check("miss_count", miss_count, m_misses[15:0]);
`endif
      end
   end

   // Presents one request and plays physical memory with the given response latency.
   task automatic access(input logic [15:0] a, input bit wr, input logic [1:0] be,
                         input logic [15:0] wd, input int lat,
                         output logic [15:0] rd, output bit saw_wb,
                         output logic [15:0] wb_addr, output logic [127:0] wb_data,
                         output bit saw_fill, output logic [15:0] fill_addr);
      int cnt = 0;
      int cyc = 0;
      bit done = 0;
      rd = 0; saw_wb = 0; wb_addr = 0; wb_data = 0; saw_fill = 0; fill_addr = 0;
      mem_address = a; mem_read = !wr; mem_write = wr;
      mem_byte_enable = be; mem_wdata = wd;
      while (!done) begin
         @(negedge clk);
         if (pmem_resp) begin
            pmem_resp = 0;
            cnt = 0;
         end
         if (mem_resp) begin
            rd   = mem_rdata;
            done = 1;
         end else begin
            if (pmem_write && !saw_wb) begin
               saw_wb = 1; wb_addr = pmem_address; wb_data = pmem_wdata;
            end
            if (pmem_read && !saw_fill) begin
               saw_fill = 1; fill_addr = pmem_address;
            end
            if (pmem_read || pmem_write) begin
               cnt++;
               if (cnt >= lat) begin
                  pmem_rdata = backing[a[15:4]];
                  pmem_resp  = 1;
               end
            end
            cyc++;
            if (cyc > 200) begin
               tests++;
               fails++;
               $display("FAIL access_timeout: addr %0h got no mem_resp, expected one within 200", a);
               done = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      mem_read  = 0;
      mem_write = 0;
      pmem_resp = 0;
   endtask

   logic [15:0]  rd, wba, fa;
   logic [127:0] wbd;
   bit           swb, sfill;

   initial begin
      for (int i = 0; i < 4096; i++)
         for (int k = 0; k < 8; k++) backing[i][k * 16 +: 16] = {12'(i), 4'(k)};
      backing[12'h123][47:32] = 16'hBEEF;

      reset = 1; mem_address = 0; mem_read = 0; mem_write = 0;
      mem_byte_enable = 0; mem_wdata = 0; pmem_rdata = 0; pmem_resp = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      check("reset_mem_resp", mem_resp, 1'b0);
      check("reset_pmem_read", pmem_read, 1'b0);
      check("reset_pmem_write", pmem_write, 1'b0);
      @(posedge clk); #1;

      // Cold read miss and fill.
      access(16'h1234, 0, 2'b11, 16'h0, 3, rd, swb, wba, wbd, sfill, fa);
      check("cold_fill_addr", fa, 16'h1230);
      check("cold_no_wb", swb, 1'b0);
      check("cold_rdata", rd, 16'hBEEF);

      // High-byte write hit then read back.
      access(16'h1235, 1, 2'b10, 16'hAB00, 3, rd, swb, wba, wbd, sfill, fa);
      check("write_hit_no_fill", sfill, 1'b0);
      access(16'h1234, 0, 2'b11, 16'h0, 3, rd, swb, wba, wbd, sfill, fa);
      check("merged_rdata", rd, 16'hABEF);

      // Conflict miss on dirty set 3.
      access(16'h12B4, 0, 2'b11, 16'h0, 2, rd, swb, wba, wbd, sfill, fa);
      check("dirty_wb_seen", swb, 1'b1);
      check("dirty_wb_addr", wba, 16'h1230);
      check("dirty_wb_word2", wbd[47:32], 16'hABEF);
      check("dirty_fill_addr", fa, 16'h12B0);
      check("dirty_rdata", rd, 16'h12B2);

      // Fill all sets, then eight back-to-back hits.
      for (int s = 0; s < 8; s++)
         access(16'h1200 + 16'(s * 16), 0, 2'b11, 16'h0, 1, rd, swb, wba, wbd, sfill, fa);
      begin
         int  n = 0;
         bit  quiet = 1;
         for (int s = 0; s < 8; s++) begin
            logic [11:0] la;
            la = 12'h120 + 12'(s);
            mem_address = 16'h1200 | 16'(s << 4) | 16'(s << 1);
            mem_read = 1;
            @(negedge clk);
            if (mem_resp) n++;
            if (pmem_read || pmem_write) quiet = 0;
            check("b2b_rdata", mem_rdata, {la, 4'(s)});
            @(posedge clk); #1;
         end
         mem_read = 0;
         check("b2b_resp_count", n, 8);
         check("b2b_pmem_quiet", quiet, 1'b1);
      end

      // Reset coincident with the fill response.
      begin
         int w = 0;
         mem_address = 16'h4000; mem_read = 1;
         @(negedge clk);
         while (!pmem_read && w < 20) begin
            @(negedge clk);
            w++;
         end
         check("rst_alloc_entered", pmem_read, 1'b1);
         pmem_rdata = backing[12'h400];
         pmem_resp  = 1;
         reset      = 1;
         @(posedge clk); #1;
         mem_read = 0; pmem_resp = 0;
         @(negedge clk);
         check("rst_pmem_read_low", pmem_read, 1'b0);
         check("rst_pmem_write_low", pmem_write, 1'b0);
         @(posedge clk); #1;
         reset = 0;
      end
      access(16'h4000, 0, 2'b11, 16'h0, 2, rd, swb, wba, wbd, sfill, fa);
      check("rst_refill_seen", sfill, 1'b1);
      check("rst_refill_rdata", rd, 16'h4000);

      // Empty byte mask still dirties the line.
      access(16'h4002, 1, 2'b00, 16'hFFFF, 2, rd, swb, wba, wbd, sfill, fa);
      access(16'h4802, 0, 2'b11, 16'h0, 2, rd, swb, wba, wbd, sfill, fa);
      check("be0_wb_seen", swb, 1'b1);
      check("be0_wb_word1", wbd[31:16], 16'h4001);
      check("be0_rdata", rd, 16'h4801);

      // Top-of-address lines index like any other.
      access(16'hFFF6, 0, 2'b11, 16'h0, 1, rd, swb, wba, wbd, sfill, fa);
      check("wrap_fill_addr", fa, 16'hFFF0);
      check("wrap_rdata", rd, 16'hFFF3);
      access(16'h0076, 0, 2'b11, 16'h0, 1, rd, swb, wba, wbd, sfill, fa);
      check("wrap_low_fill_addr", fa, 16'h0070);
      check("wrap_low_rdata", rd, 16'h0073);

`ifdef L1_DCACHE_PERF_EN
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      for (int i = 0; i < 3; i++)
         access(16'h2000 + 16'(i * 16), 0, 2'b11, 16'h0, 1, rd, swb, wba, wbd, sfill, fa);
      for (int i = 0; i < 5; i++)
         access(16'h2000, 0, 2'b11, 16'h0, 1, rd, swb, wba, wbd, sfill, fa);
      @(negedge clk);
      check("perf_miss_count", miss_count, 16'd3);
      check("perf_hit_count", hit_count, 16'd5);
      @(posedge clk); #1;
      mem_address = 16'h2000; mem_read = 1;
      repeat (65540) @(posedge clk);
      #1 mem_read = 0;
      @(negedge clk);
      check("perf_hit_saturate", hit_count, 16'hFFFF);
`endif

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
